// File: rtl/conv1x1_oc_scheduler.sv
// Output-channel sequencer for the 1x1 convolution datapath: weight/bias table, frame requests, pixel forwarding.
// Optional drain watchdog enabled by defining SCHED_TIMEOUT_EN.
module conv1x1_oc_scheduler #(
    parameter int DATA_W  = 16,
    parameter int MAX_OC  = 8,
    parameter int OC_W    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     cfg_we,
    input  logic [OC_W-1:0]          cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_weight,
    input  logic signed [DATA_W-1:0] cfg_bias,
    input  logic                     start,
    input  logic [OC_W:0]            num_oc,
    input  logic [8:0]               image_size,
    output logic                     src_frame_start,
    output logic                     src_ready,
    input  logic                     src_data_valid,
    input  logic signed [DATA_W-1:0] src_data,
    output logic                     pe_data_valid,
    output logic signed [DATA_W-1:0] pe_data,
    output logic signed [DATA_W-1:0] pe_weight,
    output logic signed [DATA_W-1:0] pe_bias,
    input  logic                     pe_frame_valid,
    output logic [OC_W-1:0]          oc_index,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, NEXT, FIN} state_t;

    state_t state, state_n;

    logic signed [DATA_W-1:0] w_tab [MAX_OC];
    logic signed [DATA_W-1:0] b_tab [MAX_OC];

    logic [OC_W:0] num_oc_r;
    logic [17:0]   total;
    logic [17:0]   count;
    logic          accept;
    logic          last_beat;
    logic          start_bad;
    logic          last_oc;
    logic          drain_exit;

`ifdef SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tcnt;
    logic           timed_out;
    assign timed_out  = (tcnt == TCW'(TIMEOUT - 1));
    assign drain_exit = pe_frame_valid | timed_out;
`else
    assign drain_exit = pe_frame_valid;
`endif

    assign accept    = src_data_valid & src_ready;
    assign last_beat = accept && (count == total - 18'd1);
    assign start_bad = (num_oc == '0) || (32'(num_oc) > MAX_OC) || (image_size == '0);
    assign last_oc   = ({1'b0, oc_index} == num_oc_r - 1'b1);

    // Table is deliberately not reset; writes only land while idle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && cfg_we && state == IDLE && 32'(cfg_addr) < MAX_OC) begin
            w_tab[cfg_addr] <= cfg_weight;
            b_tab[cfg_addr] <= cfg_bias;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = start_bad ? FIN : LOAD;
            LOAD:    state_n = STREAM;
            STREAM:  if (last_beat) state_n = DRAIN;
            DRAIN:   if (drain_exit) state_n = NEXT;
            NEXT:    state_n = last_oc ? FIN : LOAD;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            src_frame_start <= 1'b0;
            src_ready       <= 1'b0;
            pe_data_valid   <= 1'b0;
            pe_data         <= '0;
            pe_weight       <= '0;
            pe_bias         <= '0;
            oc_index        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            num_oc_r        <= '0;
            total           <= '0;
            count           <= '0;
`ifdef SCHED_TIMEOUT_EN
            tcnt            <= '0;
`endif
        end else begin
            state           <= state_n;
            // LOAD lasts one cycle, so entering it is exactly the frame request pulse.
            src_frame_start <= (state_n == LOAD);
            done            <= (state == FIN);
            pe_data_valid   <= accept;
            if (accept) pe_data <= src_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_oc_r <= num_oc;
                        total    <= 18'(image_size) * 18'(image_size);
                        oc_index <= '0;
                        err      <= start_bad;
                        busy     <= !start_bad;
                    end
                end
                LOAD: begin
                    pe_weight <= w_tab[oc_index];
                    pe_bias   <= b_tab[oc_index];
                    count     <= '0;
                    src_ready <= 1'b1;
                end
                STREAM: begin
                    if (accept) begin
                        count <= count + 18'd1;
                        if (last_beat) src_ready <= 1'b0;
                    end
`ifdef SCHED_TIMEOUT_EN
                    if (last_beat) tcnt <= '0;
`endif
                end
                DRAIN: begin
`ifdef SCHED_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
                    if (timed_out && !pe_frame_valid) err <= 1'b1;
`endif
                end
                NEXT: begin
                    if (!last_oc) oc_index <= oc_index + 1'b1;
                end
                FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv1x1_oc_scheduler.md
Name: conv1x1_oc_scheduler

Overview:
- Sequences the 1x1 convolution datapath over multiple output channels.
- Holds a per-channel weight/bias table, loaded through a config port.
- For each output channel: presents that channel's weight/bias to the datapath, requests one input frame from the pixel source, forwards image_size*image_size pixels, then waits for the datapath's frame_valid before advancing.
- Sits between the feature-map buffer (pixel source) and the one_by_one datapath.

Parameters:
- DATA_W, 16, width of pixel, weight and bias (signed)
- MAX_OC, 8, number of weight/bias table entries
- OC_W, 3, table address width (clog2 of MAX_OC)
- TIMEOUT, 1024, drain watchdog limit in cycles (used only with the optional feature)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  OC_W  table entry index
- cfg_weight  in  DATA_W  weight to write
- cfg_bias  in  DATA_W  bias to write
- start  in  1  start-of-job pulse
- num_oc  in  OC_W+1  output channels to run (1..MAX_OC); sampled on start
- image_size  in  9  frame side length; sampled on start
- src_frame_start  out  1  one-cycle request to the source to begin a frame
- src_ready  out  1  scheduler accepting pixels
- src_data_valid  in  1  source pixel valid
- src_data  in  DATA_W  source pixel, signed
- pe_data_valid  out  1  pixel valid to datapath
- pe_data  out  DATA_W  pixel to datapath
- pe_weight  out  DATA_W  current channel weight
- pe_bias  out  DATA_W  current channel bias
- pe_frame_valid  in  1  datapath end-of-frame indication
- oc_index  out  OC_W  channel currently being processed
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0. State is IDLE. Table contents are not reset (undefined until written).
- Table writes: performed at the clock edge when cfg_we=1 and state is IDLE. They are ignored while busy. cfg_addr >= MAX_OC is ignored.
- State machine: IDLE -> LOAD -> STREAM -> DRAIN -> NEXT -> (LOAD | FIN) -> IDLE.
- IDLE:
  - start=1 latches num_oc, image_size and total = image_size*image_size (18-bit, unsigned).
  - It also clears err and oc_index.
  - If num_oc==0, num_oc>MAX_OC or image_size==0: go to FIN, set err=1, no streaming.
  - Otherwise go to LOAD, busy=1.
- LOAD (1 cycle):
  - pe_weight/pe_bias are registered from table[oc_index].
  - src_frame_start=1 for this cycle only.
  - pixel count is cleared, src_ready set to 1 at exit.
  - pe_weight/pe_bias hold stable until the next LOAD.
- STREAM:
  - A beat is accepted when src_data_valid & src_ready.
  - For each accepted beat, pe_data_valid=1 and pe_data=src_data on the following cycle (1-cycle latency). Otherwise pe_data_valid=0 and pe_data holds.
  - On the beat where count==total-1: src_ready goes 0 from the next cycle and the state moves to DRAIN.
  - Source valid bubbles are allowed; count advances only on accepted beats.
- DRAIN: wait for pe_frame_valid=1, then go to NEXT. Source beats arriving while src_ready=0 are ignored (no pe_data_valid).
- NEXT (1 cycle): if oc_index==num_oc-1, go to FIN. Otherwise increment oc_index and go to LOAD.
- FIN (1 cycle): done=1, busy=0 from the next cycle, go to IDLE. oc_index holds its last value.
- pe_frame_valid outside DRAIN is ignored.
- start while busy is ignored.
- sys_rst mid-job: state returns to IDLE at that edge; all outputs 0 next cycle; no done pulse.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN
- Defined:
  - A counter runs in DRAIN.
  - If pe_frame_valid has not arrived after TIMEOUT cycles, set err=1 and go to NEXT (the job continues with the next channel).
  - The counter clears on each entry to DRAIN.
- Not defined: DRAIN waits indefinitely; the TIMEOUT parameter is unused.

Test Plan:
- Basic job:
  - Write table[0]=(w=1,b=0), [1]=(w=-2,b=3); start with num_oc=2, image_size=5; source always valid with $random%10.
  - Required: two src_frame_start pulses; 25 pe_data_valid beats per channel, pe_data equal to src_data delayed 1 cycle.
  - pe_weight=1 for the first 25 beats, then -2/3.
  - done pulses once after the second pe_frame_valid; err=0.
- Source bubbles: image_size=3 with src_data_valid toggling 1,0,1,0...
  - Required: exactly 9 beats forwarded; src_ready drops the cycle after the 9th accepted beat; extra valid beats produce no pe_data_valid.
- Illegal config:
  - start with image_size=0 -> done pulses 2 cycles later, err=1, no src_frame_start.
  - start with num_oc=9 (MAX_OC=8) -> same response.
- Busy protection: during STREAM, pulse start and write cfg_addr 0 with w=7.
  - Required: no restart; table[0] is unchanged in the next job; pe_weight never shows 7.
- Reset mid-job: assert sys_rst during DRAIN of channel 0 (num_oc=2).
  - Required: the next cycle has busy=0, src_ready=0, pe_data_valid=0, oc_index=0; no done.
  - A new start then runs normally.
- Timeout (SCHED_TIMEOUT_EN, TIMEOUT=16): tie pe_frame_valid=0, num_oc=2, image_size=2.
  - Required: each channel leaves DRAIN after 16 cycles; err=1; done pulses once.
